// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the memory stall controller.
//   state_e        : controller FSM state encoding (Idle/Busy/Done)
//   MemLatDefault  : default backing-memory read latency in cycles
//   CntWidth       : width of the latency counter
package mem_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam int unsigned MemLatDefault = 4;
  localparam int unsigned CntWidth      = 4;

endpackage

// File: rtl/lat_counter.sv
// Saturating access-latency counter.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (count -> 0)
//   clear_i  : restart the count at 1 (first cycle of an access)
//   enable_i : advance the count by one, saturating at all-ones
//   tc_o     : count has reached Terminal
module lat_counter
  import mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned Terminal = MemLatDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [CntWidth-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      // The access's first busy cycle is counted as 1.
      count_d = CntWidth'(1);
    end else if (enable_i && (count_q != {CntWidth{1'b1}})) begin
      count_d = count_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CntWidth'(Terminal));

endmodule

// File: rtl/mem_stall_ctrl.sv
// CPU-side stall controller for a fixed-latency backing memory.
// Accepts a single read or write, holds the CPU (Stall) for MEM_LAT busy cycles,
// then pulses Done for one cycle. Reads return mem_rdata on DataOut.
//   clk, rst             : clock, asynchronous active-low reset
//   Rd, Wr, Addr, DataIn : CPU request
//   DataOut, Done, Stall : CPU response / pipeline hold
//   err                  : illegal request (Rd and Wr together, or misaligned)
//   mem_rd, mem_wr       : one-cycle backing-memory strobes
//   mem_addr, mem_wdata  : latched request address / write data
//   mem_rdata            : backing-memory read data
// Optional: define ALIGN_CHECK_EN to reject requests with Addr[0]=1.
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = MemLatDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  state_e      state_q;
  logic        op_wr_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic        done_q, mem_rd_q, mem_wr_q;

  logic accepting, misaligned, req_ok, req_bad, cnt_tc;

`ifdef ALIGN_CHECK_EN
  assign misaligned = Addr[0];
`else
  assign misaligned = 1'b0;
`endif

  // Done behaves like Idle for accepting a new request.
  assign accepting = (state_q == StIdle) || (state_q == StDone);
  assign req_ok    = accepting && (Rd ^ Wr) && !misaligned;
  assign req_bad   = accepting && (Rd || Wr) && !req_ok;

  lat_counter #(
    .Terminal (MEM_LAT)
  ) u_lat_counter (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (req_ok),
    .enable_i (state_q == StBusy),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      // Strobes and Done are single-cycle pulses.
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (req_ok) begin
            state_q  <= StBusy;
            op_wr_q  <= Wr;
            addr_q   <= Addr;
            wdata_q  <= DataIn;
            mem_rd_q <= Rd;
            mem_wr_q <= Wr;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          // Rd/Wr are ignored here; the latched access runs to completion.
          if (cnt_tc) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            if (!op_wr_q) begin
              rdata_q <= mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign DataOut   = rdata_q;
  assign Done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Stall     = (state_q == StBusy) || req_ok;
  // Gated by reset so err is held low while rst is asserted.
  assign err       = rst && req_bad;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
module tb_mem_stall_ctrl;

  localparam int unsigned MEM_LAT = 4;
`ifdef ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  logic        clk, rst, Rd, Wr;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic        Done, Stall, err, mem_rd, mem_wr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stall_ctrl #(
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rd        (Rd),
    .Wr        (Wr),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .err       (err),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Backing memory: read data is valid only in the cycle MEM_LAT-1 after mem_rd.
  int          cyc    = 0;
  int          rd_due = -1;
  logic [15:0] rd_data = 16'h0000;

  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      rd_due  = cyc + int'(MEM_LAT) - 1;
      rd_data = mem_model(mem_addr);
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    mem_rdata = (cyc == rd_due) ? rd_data : ~rd_data;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_err;
    logic        exp_acc;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  // One request from Idle; watches it through Done and back to Idle.
  task automatic run_row(input vec_t v);
    Rd = v.rd; Wr = v.wr; Addr = v.addr; DataIn = v.din;
    @(negedge clk);
    chk1("row_stall_c0", Stall, v.exp_acc);
    chk1("row_err_c0", err, v.exp_err);
    next_cycle();
    Rd = 1'b0; Wr = 1'b0;
    for (int c = 1; c <= int'(MEM_LAT) + 1; c++) begin
      @(negedge clk);
      chk1("row_mem_rd", mem_rd, v.exp_acc && v.rd && (c == 1));
      chk1("row_mem_wr", mem_wr, v.exp_acc && v.wr && (c == 1));
      chk1("row_done", Done, v.exp_acc && (c == int'(MEM_LAT) + 1));
      chk1("row_stall", Stall, v.exp_acc && (c <= int'(MEM_LAT)));
      chk1("row_err", err, 1'b0);
      if (v.exp_acc && c <= int'(MEM_LAT)) begin
        chk16("row_mem_addr", mem_addr, v.addr);
        chk16("row_mem_wdata", mem_wdata, v.din);
      end
      next_cycle();
    end
    chk16("row_dataout", DataOut, v.exp_dout);
  endtask

  // Random-phase reference model: whole accesses tracked as cycle intervals.
  int          start_c, busy_end, done_c;
  logic        cur_rd, cur_wr;
  logic [15:0] cur_addr, cur_din, cur_val, e_dout;

  initial begin
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    #12;
    chk16("rst_dataout", DataOut, 16'h0000);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_mem_wdata", mem_wdata, 16'h0000);
    chk1("rst_stall", Stall, 1'b0);
    Rd = 1'b1; Wr = 1'b1;
    #1;
    chk1("rst_err_gated", err, 1'b0);
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 16'h0011, 16'h0000, AlignCheck, !AlignCheck,
                AlignCheck ? 16'hBEEF : mem_model(16'h0011)};
    vecs[4] = '{1'b1, 1'b0, 16'h0040, 16'h5555, 1'b0, 1'b1, mem_model(16'h0040)};
    vecs[5] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, mem_model(16'h0040)};
    for (int i = 0; i < 6; i++) run_row(vecs[i]);

    // Back-to-back read then write issued in the Done cycle; a Rd+Wr glitch while busy.
    for (int c = 0; c <= 10; c++) begin
      Rd = (c == 0) || (c == 2);
      Wr = (c == 5) || (c == 2);
      if (c == 0) begin Addr = 16'h0050; DataIn = 16'h0000; end
      if (c == 2) Addr = 16'h0099;
      if (c == 5) begin Addr = 16'h0060; DataIn = 16'hCAFE; end
      @(negedge clk);
      chk1("b2b_stall", Stall, c <= 9);
      chk1("b2b_done", Done, (c == 5) || (c == 10));
      chk1("b2b_err", err, 1'b0);
      chk1("b2b_mem_rd", mem_rd, c == 1);
      chk1("b2b_mem_wr", mem_wr, c == 6);
      if (c == 3) chk16("b2b_addr_held", mem_addr, 16'h0050);
      if (c == 6) begin
        chk16("b2b_wr_addr", mem_addr, 16'h0060);
        chk16("b2b_wr_data", mem_wdata, 16'hCAFE);
      end
      if (c == 5 || c == 10) chk16("b2b_dataout", DataOut, mem_model(16'h0050));
      next_cycle();
    end
    Rd = 1'b0; Wr = 1'b0;

    // Reset in cycle 3 of a read abandons it.
    Rd = 1'b1; Addr = 16'h0070; DataIn = 16'h0000;
    next_cycle();
    Rd = 1'b0;
    next_cycle();
    next_cycle();
    #2 rst = 1'b0;
    #1;
    chk16("rstbusy_dataout", DataOut, 16'h0000);
    chk16("rstbusy_mem_addr", mem_addr, 16'h0000);
    chk1("rstbusy_done", Done, 1'b0);
    chk1("rstbusy_stall", Stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      chk1("rstbusy_no_done", Done, 1'b0);
    end
    next_cycle();
    run_row('{1'b1, 1'b0, 16'h0080, 16'h0000, 1'b0, 1'b1, mem_model(16'h0080)});

    // Randomized traffic against the interval model.
    start_c = -10; busy_end = -1; done_c = -1;
    cur_rd = 1'b0; cur_wr = 1'b0; cur_addr = '0; cur_din = '0; cur_val = '0;
    e_dout = mem_model(16'h0080);
    for (int t = 0; t < 500; t++) begin
      int unsigned r;
      logic free, legal, e_done, e_stall, e_err, e_mrd, e_mwr, in_busy;
      r = $urandom_range(0, 7);
      Rd = (r <= 2) || (r == 5);
      Wr = (r == 3) || (r == 4) || (r == 5);
      Addr = 16'($urandom);
      DataIn = 16'($urandom);
      e_done = (t == done_c);
      if (e_done && cur_rd) e_dout = cur_val;
      free = (t > busy_end);
      legal = (Rd ^ Wr) && !(AlignCheck && Addr[0]);
      e_stall = !free || (legal && free);
      e_err = free && (Rd || Wr) && !legal;
      e_mrd = (t == start_c + 1) && cur_rd;
      e_mwr = (t == start_c + 1) && cur_wr;
      in_busy = (t > start_c) && (t <= busy_end);
      @(negedge clk);
      chk1("rnd_stall", Stall, e_stall);
      chk1("rnd_err", err, e_err);
      chk1("rnd_done", Done, e_done);
      chk1("rnd_mem_rd", mem_rd, e_mrd);
      chk1("rnd_mem_wr", mem_wr, e_mwr);
      chk16("rnd_dataout", DataOut, e_dout);
      if (in_busy) begin
        chk16("rnd_mem_addr", mem_addr, cur_addr);
        chk16("rnd_mem_wdata", mem_wdata, cur_din);
      end
      if (free && legal) begin
        start_c  = t;
        busy_end = t + int'(MEM_LAT);
        done_c   = t + int'(MEM_LAT) + 1;
        cur_rd   = Rd;
        cur_wr   = Wr;
        cur_addr = Addr;
        cur_din  = DataIn;
        cur_val  = mem_model(Addr);
      end
      next_cycle();
    end
    Rd = 1'b0; Wr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
